// File: rtl/uart_tx_frame_if.sv
// Word-level handshake between the producer and the framed UART transmitter.
// The producer drives the master side; the transmitter takes the slave side.
interface uart_tx_frame_if #(
  parameter int PAYLOAD_W = 160
);
  logic [PAYLOAD_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Sends one PAYLOAD_W-bit word as NCHARS back-to-back UART characters, LSB first,
// with configurable data width, parity and stop bits and an internal bit-period counter.
module uart_tx_frame #(
  parameter int PAYLOAD_W    = 160,
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  uart_tx_frame_if.slave                         bus,
  output logic                                   tx,
  output logic                                   busy,
  output logic [$clog2(PAYLOAD_W/DATA_BITS):0]   char_idx,
  output logic                                   frame_done
);

  localparam int NCHARS = PAYLOAD_W / DATA_BITS;
  localparam int IDX_W  = $clog2(NCHARS) + 1;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] CHAR_LAST = IDX_W'(NCHARS - 1);
  localparam bit               HAS_PAR   = (PARITY != 0);
  localparam bit               ODD_PAR   = (PARITY == 2);

  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [PAYLOAD_W-1:0] shift_reg;
  logic                 parity_bit;
  logic                 bit_end;

  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign bus.in_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);

  // tx is registered and updated together with every state/bit change, so the
  // line always reflects the bit being timed by baud_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      char_idx   <= '0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        baud_cnt <= '0;
        if (bus.in_valid) begin
          shift_reg <= bus.in_data;
          state     <= S_START;
          bit_cnt   <= '0;
          char_idx  <= '0;
          tx        <= 1'b0;
        end
      end else if (!bit_end) begin
        baud_cnt <= baud_cnt + 1'b1;
      end else begin
        baud_cnt <= '0;
        case (state)
          S_START: begin
            state      <= S_DATA;
            bit_cnt    <= '0;
            tx         <= shift_reg[0];
            parity_bit <= (^shift_reg[DATA_BITS-1:0]) ^ ODD_PAR;
          end
          // Shifting the whole word leaves the next character's LSB at bit 0.
          S_DATA: begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (HAS_PAR) begin
                state <= S_PAR;
                tx    <= parity_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_reg[1];
            end
          end
          S_PAR: begin
            state   <= S_STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end
          S_STOP: begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (char_idx == CHAR_LAST) begin
                state      <= S_IDLE;
                char_idx   <= '0;
                frame_done <= 1'b1;
                tx         <= 1'b1;
              end else begin
                state    <= S_START;
                char_idx <= char_idx + 1'b1;
                tx       <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
